// File: rtl/decodificador_trama_pkg.sv
// Shared definitions for the frame parser: parser state encoding, default
// parameter values and fixed frame-format widths.
package decodificador_trama_pkg;

    // Parser states (3-bit encoding).
    typedef enum logic [2:0] {
        StHunt = 3'd0,
        StCmd  = 3'd1,
        StLen  = 3'd2,
        StData = 3'd3,
        StChk  = 3'd4
    } state_e;

    localparam logic [7:0]  DefSyncByte      = 8'hA5;
    localparam int unsigned DefMaxLen        = 4;
    localparam int unsigned DefTimeoutCycles = 1000;

    // Width of the LEN output field and of the inter-byte timeout counter.
    localparam int unsigned LenW = 3;
    localparam int unsigned TmrW = 16;

endpackage

// File: rtl/decodificador_trama_if.sv
// Byte-in / frame-out bus of the frame parser.
//   din, rcv          : received byte and its one-cycle strobe
//   frame_valid/ack   : output frame handshake
//   cmd, len, payload : held frame contents
//   err_chk, err_len, err_timeout, overrun : one-cycle drop pulses
// slave  = parser side, master = byte source / frame consumer side.
interface decodificador_trama_if
    import decodificador_trama_pkg::*;
#(
    parameter int unsigned MAX_LEN = DefMaxLen
) ();

    logic [7:0]           din;
    logic                 rcv;
    logic                 frame_valid;
    logic                 frame_ack;
    logic [7:0]           cmd;
    logic [LenW-1:0]      len;
    logic [8*MAX_LEN-1:0] payload;
    logic                 err_chk;
    logic                 err_len;
    logic                 err_timeout;
    logic                 overrun;

    modport master (
        output din, rcv, frame_ack,
        input  frame_valid, cmd, len, payload, err_chk, err_len, err_timeout, overrun
    );

    modport slave (
        input  din, rcv, frame_ack,
        output frame_valid, cmd, len, payload, err_chk, err_len, err_timeout, overrun
    );

endinterface

// File: rtl/temporizador_trama.sv
// Inter-byte timeout counter.
//   clk_in, reset : clock, asynchronous active-low reset
//   clr           : clear the counter (has priority)
//   en            : count one cycle
//   expired       : counter has reached TIMEOUT_CYCLES
module temporizador_trama
    import decodificador_trama_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
    input  logic clk_in,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TmrW-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == TmrW'(TIMEOUT_CYCLES));

    // Holds at the limit so an unconsumed expiry never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/decodificador_trama.sv
// Byte-level frame parser: SYNC, CMD, LEN, payload, XOR checksum.
//   clk_in, reset : clock, asynchronous active-low reset
//   bus (slave)   : byte input, frame output handshake and drop pulses
// Validated frames go to a holding register separate from the parse buffer,
// so parsing continues while a frame waits for its ack.
module decodificador_trama
    import decodificador_trama_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = DefSyncByte,
    parameter int unsigned MAX_LEN        = DefMaxLen,
    parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
    input  logic                  clk_in,
    input  logic                  reset,
    decodificador_trama_if.slave  bus
);

    localparam int unsigned PW      = 8 * MAX_LEN;
    localparam logic [7:0]  MaxLenB = 8'(MAX_LEN);

    state_e state_q, state_d;

    logic [7:0]      cmd_cand_q, cmd_cand_d;
    logic [7:0]      chk_q, chk_d;
    logic [LenW-1:0] len_cand_q, len_cand_d;
    logic [2:0]      idx_q, idx_d;
    logic [PW-1:0]   buf_q, buf_d;

    logic            fv_q, fv_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [LenW-1:0] len_q, len_d;
    logic [PW-1:0]   pay_q, pay_d;
    logic            err_chk_q, err_chk_d;
    logic            err_len_q, err_len_d;
    logic            err_to_q, err_to_d;
    logic            ovr_q, ovr_d;

    logic in_frame, tmr_expired, timeout_ev, len_bad, chk_ev, good;

    assign in_frame   = (state_q != StHunt);
    // A byte on the expiry cycle wins over the timeout.
    assign timeout_ev = in_frame && tmr_expired && !bus.rcv;
    assign len_bad    = bus.rcv && (state_q == StLen) && (bus.din > MaxLenB);
    assign chk_ev     = bus.rcv && (state_q == StChk);
    assign good       = chk_ev && (bus.din == chk_q);

    temporizador_trama #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tmr (
        .clk_in  (clk_in),
        .reset   (reset),
        .clr     (bus.rcv || !in_frame || timeout_ev),
        .en      (in_frame),
        .expired (tmr_expired)
    );

    // State register.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q <= StHunt;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (timeout_ev) begin
            state_d = StHunt;
        end else if (bus.rcv) begin
            unique case (state_q)
                StHunt: if (bus.din == SYNC_BYTE) state_d = StCmd;
                StCmd:  state_d = StLen;
                StLen: begin
                    if (bus.din > MaxLenB)     state_d = StHunt;
                    else if (bus.din == 8'd0)  state_d = StChk;
                    else                       state_d = StData;
                end
                StData: if (idx_q == len_cand_q - 3'd1) state_d = StChk;
                StChk:  state_d = StHunt;
                default: state_d = StHunt;
            endcase
        end
    end

    // Datapath and output next values.
    always_comb begin
        cmd_cand_d = cmd_cand_q;
        chk_d      = chk_q;
        len_cand_d = len_cand_q;
        idx_d      = idx_q;
        buf_d      = buf_q;
        fv_d       = fv_q;
        cmd_d      = cmd_q;
        len_d      = len_q;
        pay_d      = pay_q;
        err_chk_d  = chk_ev && !good;
        err_len_d  = len_bad;
        err_to_d   = timeout_ev;
        ovr_d      = 1'b0;

        if (bus.rcv) begin
            unique case (state_q)
                StHunt: begin
                    if (bus.din == SYNC_BYTE) begin
                        buf_d = '0;
                        idx_d = '0;
                    end
                end
                StCmd: begin
                    cmd_cand_d = bus.din;
                    chk_d      = bus.din;
                end
                StLen: begin
                    if (!len_bad) begin
                        len_cand_d = bus.din[LenW-1:0];
                        chk_d      = chk_q ^ bus.din;
                        idx_d      = '0;
                    end
                end
                StData: begin
                    buf_d[8*idx_q +: 8] = bus.din;
                    chk_d               = chk_q ^ bus.din;
                    idx_d               = idx_q + 3'd1;
                end
                StChk: ;
                default: ;
            endcase
        end

        if (good) begin
            if (!fv_q || bus.frame_ack) begin
                fv_d  = 1'b1;
                cmd_d = cmd_cand_q;
                len_d = len_cand_q;
                pay_d = buf_q;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (fv_q && bus.frame_ack) begin
            fv_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            cmd_cand_q <= '0;
            chk_q      <= '0;
            len_cand_q <= '0;
            idx_q      <= '0;
            buf_q      <= '0;
            fv_q       <= 1'b0;
            cmd_q      <= '0;
            len_q      <= '0;
            pay_q      <= '0;
            err_chk_q  <= 1'b0;
            err_len_q  <= 1'b0;
            err_to_q   <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            cmd_cand_q <= cmd_cand_d;
            chk_q      <= chk_d;
            len_cand_q <= len_cand_d;
            idx_q      <= idx_d;
            buf_q      <= buf_d;
            fv_q       <= fv_d;
            cmd_q      <= cmd_d;
            len_q      <= len_d;
            pay_q      <= pay_d;
            err_chk_q  <= err_chk_d;
            err_len_q  <= err_len_d;
            err_to_q   <= err_to_d;
            ovr_q      <= ovr_d;
        end
    end

    assign bus.frame_valid = fv_q;
    assign bus.cmd         = cmd_q;
    assign bus.len         = len_q;
    assign bus.payload     = pay_q;
    assign bus.err_chk     = err_chk_q;
    assign bus.err_len     = err_len_q;
    assign bus.err_timeout = err_to_q;
    assign bus.overrun     = ovr_q;

endmodule

// File: doc/decodificador_trama.md
Name: decodificador_trama

Overview:
Byte-level frame parser that sits directly downstream of the Bluetooth UART receiver. It consumes each received byte, qualified by a one-cycle strobe, and hunts for a sync byte. It then assembles a command frame (CMD, LEN, payload, XOR checksum) and presents each validated frame to the game logic through a valid/ack handshake. Malformed, stalled or unconsumed frames are dropped, and each drop raises a one-cycle error pulse.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker.
MAX_LEN, 4, maximum payload bytes accepted (1..4); sets the payload bus width of 8*MAX_LEN.
TIMEOUT_CYCLES, 1000, clk_in cycles allowed between bytes inside a frame (16-bit counter).

Ports:
clk_in  input  1  clock; same clock domain as the byte strobe.
reset  input  1  asynchronous, active-low reset (0 = reset).
din  input  8  received byte; valid only when rcv=1.
rcv  input  1  one-cycle byte strobe.
frame_valid  output  1  a validated frame is held on the outputs.
frame_ack  input  1  consumer accepts the frame; sampled only while frame_valid=1.
cmd  output  8  frame command byte.
len  output  3  payload length, 0..MAX_LEN.
payload  output  8*MAX_LEN  byte i on bits [8i+7:8i]; bytes beyond len are zero.
err_chk  output  1  one-cycle pulse: checksum mismatch.
err_len  output  1  one-cycle pulse: LEN > MAX_LEN.
err_timeout  output  1  one-cycle pulse: inter-byte timeout.
overrun  output  1  one-cycle pulse: completed frame dropped because the output was still pending.

Behaviour:
- Reset, asynchronous, reset=0: state HUNT. All outputs 0, including cmd, len, payload, frame_valid and all pulses. Internal buffers and counter are cleared. A reset mid-frame discards the partial frame.
- States and transitions, taken only on cycles with rcv=1:
  - HUNT: din==SYNC_BYTE -> CMD. Any other byte is ignored.
  - CMD: store din as the cmd candidate; chk<=din; -> LEN.
  - LEN: if din>MAX_LEN -> err_len pulse, -> HUNT. Otherwise store len and chk^=din. len==0 -> CHK; else -> DATA with idx=0.
  - DATA: buf[idx]<=din; chk^=din; idx++. When idx==len-1 -> CHK.
  - CHK: if din==chk, the frame is good; else err_chk pulse. -> HUNT in both cases.
- Checksum is the XOR of CMD, LEN and all payload bytes. The SYNC byte is excluded.
- SYNC_BYTE received mid-frame is treated as ordinary data; there is no resync.
- Output load:
  - A good frame is loaded on the CHK strobe cycle if frame_valid==0, or if frame_valid==1 and frame_ack==1 in that same cycle.
  - frame_valid=1 from the next cycle; latency is 1 cycle from the CHK strobe.
  - Otherwise the held frame is kept unchanged and overrun pulses.
- Handshake:
  - frame_ack=1 with frame_valid=1 and no new load: frame_valid=0 next cycle.
  - cmd, len and payload stay stable while frame_valid=1.
  - frame_ack while frame_valid=0 is ignored.
- Parsing continues while a frame is pending. The holding register and the parse buffer are separate.
- Timeout:
  - The counter clears on every rcv and while in HUNT, and increments otherwise.
  - When it reaches TIMEOUT_CYCLES in CMD, LEN, DATA or CHK: err_timeout pulse, -> HUNT, counter cleared.
  - If rcv coincides with the timeout cycle, the byte wins and no timeout is raised.
- Error pulses are mutually exclusive per cycle and last exactly one cycle. The parse buffer is zero-filled on each SYNC detection.

Decomposition:
- Shared package holds: state encoding (HUNT, CMD, LEN, DATA, CHK as 3-bit localparams), the default SYNC_BYTE, and the frame-format constants.
- One sub-module is natural: temporizador_trama, the inter-byte timeout counter with clear/enable inputs and an expiry pulse output.

Test Plan:
- Good frame A5 10 02 3C 5A 74 -> frame_valid 1 cycle after the last strobe; cmd=0x10, len=2, payload=32'h00005A3C. Hold without ack for 20 cycles and check the outputs stay stable; ack -> frame_valid=0 next cycle.
- Same frame with checksum 0x75 -> err_chk single pulse, frame_valid stays 0. A following good frame parses correctly.
- A5 10 05 -> err_len pulse on the LEN strobe. Next bytes 3C 5A are ignored in HUNT.
- A5 10, then no rcv for TIMEOUT_CYCLES -> err_timeout pulse, state HUNT. Also: a byte arriving exactly on the expiry cycle produces no timeout.
- Two good frames with no ack (A5 20 00 20, then A5 10 02 3C 5A 74) -> first frame retained (cmd=0x20, len=0, payload=0) and overrun pulse. Repeat with ack asserted on the second CHK cycle -> second frame loaded, no overrun.
- Assert reset=0 after A5 10 02 3C -> all outputs 0. After release, a complete good frame is decoded correctly.
